// File: rtl/stream_width_upsizer.sv
`default_nettype none
// ============================================================================
// stream_width_upsizer: packs RATIO narrow beats into one registered wide word
// Revision: 1.0
// ============================================================================
module stream_width_upsizer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      input_valid_i,
  output logic                      input_ready_o,
  input  logic [IN_WIDTH-1:0]       input_data_i,
  input  logic                      input_last_i,
  output logic                      output_valid_o,
  input  logic                      output_ready_i,
  output logic [IN_WIDTH*RATIO-1:0] output_data_o,
  output logic [RATIO-1:0]          output_keep_o,
  output logic                      output_last_o
);

  localparam int CW = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam int OW = IN_WIDTH * RATIO;

  generate
    if (RATIO < 2) begin : g_ratio_check
      $error("stream_width_upsizer: RATIO must be >= 2");
    end
  endgenerate

  logic [OW-1:0]    acc_data;
  logic [RATIO-1:0] acc_keep;
  logic [CW-1:0]    cnt;
  logic [OW-1:0]    word_data;
  logic [RATIO-1:0] word_keep;
  logic             accept;
  logic             complete;

  assign input_ready_o = !output_valid_o || output_ready_i;
  assign accept        = input_valid_i && input_ready_o;
  assign complete      = (cnt == CW'(RATIO - 1)) || input_last_i;

  // Accumulator with the current beat merged into lane cnt
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CW'(k)) begin
        word_data[k*IN_WIDTH +: IN_WIDTH] = input_data_i;
        word_keep[k]                      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      output_valid_o <= 1'b0;
      output_data_o  <= '0;
      output_keep_o  <= '0;
      output_last_o  <= 1'b0;
      acc_data       <= '0;
      acc_keep       <= '0;
      cnt            <= '0;
    end else if (clear_i) begin
      output_valid_o <= 1'b0;
      output_data_o  <= '0;
      output_keep_o  <= '0;
      output_last_o  <= 1'b0;
      acc_data       <= '0;
      acc_keep       <= '0;
      cnt            <= '0;
    end else begin
      if (output_valid_o && output_ready_i) begin
        output_valid_o <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          // Load overrides the drain above, giving back-to-back words
          output_valid_o <= 1'b1;
          output_data_o  <= word_data;
          output_keep_o  <= word_keep;
          output_last_o  <= input_last_i;
          acc_data       <= '0;
          acc_keep       <= '0;
          cnt            <= '0;
        end else begin
          acc_data <= word_data;
          acc_keep <= word_keep;
          cnt      <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_width_upsizer.sv
`default_nettype none
// ============================================================================
// tb_stream_width_upsizer: directed + random stimulus against a beat-queue model
// Revision: 1.0
// ============================================================================
module tb_stream_width_upsizer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int OW = W * R;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [R-1:0]  out_keep;
  logic          out_last;

  stream_width_upsizer #(.IN_WIDTH(W), .RATIO(R)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .input_valid_i  (in_valid),
    .input_ready_o  (in_ready),
    .input_data_i   (in_data),
    .input_last_i   (in_last),
    .output_valid_o (out_valid),
    .output_ready_i (out_ready),
    .output_data_o  (out_data),
    .output_keep_o  (out_keep),
    .output_last_o  (out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a pending output word plus the list of beats gathered so far
  logic          m_valid;
  logic [OW-1:0] m_data;
  logic [R-1:0]  m_keep;
  logic          m_last;
  logic [W-1:0]  beats[$];

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_last  = 1'b0;
    beats.delete();
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the model
  task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                      input logic rdy, input logic clr);
    logic exp_ready;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = rdy;
    clear_i   = clr;
    @(negedge clk);
    exp_ready = !m_valid || rdy;
    check_val("in_ready", 64'(in_ready), 64'(exp_ready));
    check_val("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check_val("out_data", 64'(out_data), 64'(m_data));
      check_val("out_keep", 64'(out_keep), 64'(m_keep));
      check_val("out_last", 64'(out_last), 64'(m_last));
    end
    if (clr) begin
      model_reset();
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (v && exp_ready) begin
        beats.push_back(d);
        if (beats.size() == R || l) begin
          m_data = '0;
          foreach (beats[i]) m_data = m_data | (OW'(beats[i]) << (W * i));
          m_keep  = R'((1 << beats.size()) - 1);
          m_last  = l;
          m_valid = 1'b1;
          beats.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    clear_i   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_keep", 64'(out_keep), 64'd0);

    // Asynchronous reset in the middle of a word
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_val("arst_valid", 64'(out_valid), 64'd0);
    check_val("arst_data", 64'(out_data), 64'd0);
    check_val("arst_keep", 64'(out_keep), 64'd0);
    check_val("arst_last", 64'(out_last), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hA0 + i), 1'b0, 1'b1, 1'b0);
    check_val("post_rst_data", 64'(out_data), 64'h00A3A2A1A0);
    idle(1'b1);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
    check_val("stream_w2", 64'(out_data), 64'h0007060504);
    idle(1'b1);

    // Short packet then refill from lane 0
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
    check_val("short_data", 64'(out_data), 64'h0000006655);
    check_val("short_keep", 64'(out_keep), 64'h3);
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hC0 + i), 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // Backpressure: word pending, 10 stalled cycles, then release
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b1, W'(8'hE0 + i), 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // Single-beat packet
    step(1'b1, 8'h9C, 1'b1, 1'b1, 1'b0);
    check_val("single_data", 64'(out_data), 64'h000000009C);
    check_val("single_keep", 64'(out_keep), 64'h1);
    idle(1'b1);

    // Clear with a pending word and a beat presented
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    // Clear with a partial word
    step(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'hB0, 1'b1, 1'b1, 1'b0);
    check_val("clr_keep", 64'(out_keep), 64'h1);
    check_val("clr_data", 64'(out_data), 64'h00000000B0);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) == 0));
    end
    repeat (3) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_width_upsizer.md
Name: stream_width_upsizer

Overview:
- Stage directly downstream of the pipeline skid buffer.
- Consumes a stream of IN_WIDTH-bit beats and packs RATIO consecutive beats into one wide word for wide consumers such as memory writers and wide FIFOs.
- Packet boundaries are honoured: input_last_i closes a word early, and lane-valid flags mark the populated lanes.
- Both sides use valid/ready handshakes. Output data is registered.

Parameters:
- IN_WIDTH, 32: width of one input beat in bits.
- RATIO, 4: beats per output word. Must be >= 2; elaboration fails otherwise.

Ports:
- clk_i  input  1  clock. All state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous flush; active high.
- input_valid_i  input  1  input beat valid.
- input_ready_o  output  1  stage accepts an input beat this cycle.
- input_data_i  input  IN_WIDTH  input beat data.
- input_last_i  input  1  beat is the final beat of its packet.
- output_valid_o  output  1  packed word valid.
- output_ready_i  input  1  downstream accepts the word.
- output_data_o  output  IN_WIDTH*RATIO  packed word. Lane k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- output_keep_o  output  RATIO  bit k set means lane k holds a valid beat.
- output_last_o  output  1  word contains the packet's final beat.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - output_valid_o=0, output_data_o=0, output_keep_o=0, output_last_o=0.
  - Lane counter=0, accumulator data and keep=0.
  - Takes effect immediately, including mid-word. Any partial word is discarded.
- clear_i high at an edge: same effect as reset, applied synchronously. clear_i dominates any handshake in the same cycle; a beat presented in that cycle is dropped.
- Handshakes:
  - Input beat accepted when input_valid_i && input_ready_o.
  - Output word transferred when output_valid_o && output_ready_i.
- input_ready_o = !output_valid_o || output_ready_i. Combinational from output_ready_i. The upstream skid buffer breaks this path.
- Lane counter cnt has width $clog2(RATIO) and starts at 0.
- On each accepted beat:
  - Data is written to accumulator lane cnt, and keep bit cnt is set.
  - If cnt==RATIO-1 or input_last_i=1, the word completes. The accumulator content plus the current beat loads the output register on the same edge.
  - On completion: output_keep_o equals the accumulated keep bits; output_last_o=input_last_i; unfilled lanes of output_data_o are 0.
  - After completion, cnt returns to 0 and the accumulator data and keep are zeroed.
  - Otherwise cnt increments by 1.
- Latency: output_valid_o rises on the edge that accepts the completing beat, i.e. one cycle after the beat is presented.
- Output register:
  - Holds the word stable while output_valid_o && !output_ready_i.
  - Cleared to valid=0 after a transfer unless a new word loads on the same edge.
  - A transfer and a load in the same cycle replace the word back-to-back, giving full throughput.
- Throughput: one input beat per cycle while downstream is ready; RATIO input beats per output word.
- Stall: while the output register is full and not draining, input_ready_o=0, including for non-completing beats. No beats are lost and none are reordered.
- Last on lane RATIO-1 produces a full keep with last=1. Last on lane 0 produces keep=...0001 with last=1.
- Accumulator state persists across idle cycles; there is no timeout flush.

Test Plan (IN_WIDTH=8, RATIO=4):
- Reset mid-word: send 0x11, 0x22, assert rst_ni=0 → all outputs 0 immediately. After release, send 0xA0..0xA3 → data=0xA3A2A1A0, keep=0xF, last=0 (no stale lanes).
- Streaming, output_ready_i=1: send 0x00..0x07 back-to-back → two words, 0x03020100 then 0x07060504; input_ready_o held at 1; valid one cycle after beats 3 and 7.
- Short packet: send 0x55, then 0x66 with last=1 → data=0x00006655, keep=0x3, last=1. The next beats fill from lane 0.
- Backpressure: hold output_ready_i=0 with a word pending → input_ready_o=0 and output stable for 10 cycles. Release → word transfers and the following beat is accepted that same cycle.
- Single-beat packet: 0x9C with last=1 → data=0x0000009C, keep=0x1, last=1.
- clear_i with valid beat and pending word: both discarded; output_valid_o=0 and cnt=0 next cycle.
